// File: rtl/wb_ram_responder.sv
// Pipelined-Wishbone slave backed by a single-port word RAM. One transfer
// at a time, acked WAIT_STATES+1 cycles after acceptance.
module wb_ram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_stall_o,
  output logic        wb_ack_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    ack_q;
  logic                    stall_q;
  logic [31:0]             rdat_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic                    we_q;
  logic [3:0]              sel_q;
  logic [31:0]             wdat_q;

  logic [31:0]             mem [DEPTH];

  logic                    accept;
  logic [ADDR_WIDTH-1:0]   adr_idx;
  logic                    commit_en;
  logic [ADDR_WIDTH-1:0]   commit_idx;
  logic                    commit_we;
  logic [3:0]              commit_sel;
  logic [31:0]             commit_dat;

  // Byte offset and upper address bits are deliberately dropped (wrap).
  logic unused_adr_bits;
  assign unused_adr_bits = ^{wb_adr_i[31:ADDR_WIDTH+2], wb_adr_i[1:0]};

  assign adr_idx = wb_adr_i[ADDR_WIDTH+1:2];
  assign accept  = (state_q == S_IDLE) && wb_cyc_i && wb_stb_i && !stall_q;

  // commit_en marks the edge that enters ACK; with no wait states that is
  // the acceptance edge itself, so the request comes straight from the bus.
  always_comb begin
    commit_en  = 1'b0;
    commit_idx = idx_q;
    commit_we  = we_q;
    commit_sel = sel_q;
    commit_dat = wdat_q;
    if (accept && (WAIT_STATES == 0)) begin
      commit_en  = 1'b1;
      commit_idx = adr_idx;
      commit_we  = wb_we_i;
      commit_sel = wb_sel_i;
      commit_dat = wb_dat_i;
    end else if ((state_q == S_WAIT) && (cnt_q == 4'd0)) begin
      commit_en  = 1'b1;
    end
  end

  // NOTE: the RAM array has no reset branch; contents survive rst_i and the
  // array maps onto block RAM, which has no bulk clear.
  always_ff @(posedge clk_i) begin
    if (commit_en && commit_we) begin
      for (int b = 0; b < 4; b++) begin
        if (commit_sel[b]) mem[commit_idx][8*b +: 8] <= commit_dat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      stall_q <= 1'b0;
      rdat_q  <= 32'h0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      wdat_q  <= 32'h0;
    end else begin
      ack_q <= commit_en;
      if (commit_en && !commit_we) rdat_q <= mem[commit_idx];
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            idx_q   <= adr_idx;
            we_q    <= wb_we_i;
            sel_q   <= wb_sel_i;
            wdat_q  <= wb_dat_i;
            stall_q <= 1'b1;
            if (WAIT_STATES == 0) begin
              state_q <= S_ACK;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) state_q <= S_ACK;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        S_ACK: begin
          state_q <= S_IDLE;
          stall_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_stall_o = stall_q;
  assign wb_dat_o   = rdat_q;

endmodule

// File: tb/tb_wb_ram_responder.sv
// Directed bench for wb_ram_responder: one instance with no wait states and
// one with three, sharing clock, reset and the data-side bus signals.
module tb_wb_ram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc0 = 1'b0, stb0 = 1'b0, cyc3 = 1'b0, stb3 = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic        ack0, stall0, ack3, stall3;
  logic [31:0] dat0, dat3;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  wb_ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc0), .wb_stb_i(stb0),
    .wb_stall_o(stall0), .wb_ack_o(ack0), .wb_we_i(we), .wb_sel_i(sel),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat0)
  );

  wb_ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc3), .wb_stb_i(stb3),
    .wb_stall_o(stall3), .wb_ack_o(ack3), .wb_we_i(we), .wb_sel_i(sel),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat3)
  );

  // Issues one request, drops cyc/stb right after the acceptance edge, and
  // watches a fixed 12-cycle window. pulse_at > 0 re-raises stb for that one
  // cycle. lat is the cycle of the first ack (-1 if none).
  task automatic xfer(input bit d3, input logic w, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] d, input int pulse_at,
                      output int lat, output int n_ack, output logic [31:0] rdata);
    we = w; sel = s; adr = a; wdat = d;
    if (d3) begin cyc3 = 1'b1; stb3 = 1'b1; end
    else    begin cyc0 = 1'b1; stb0 = 1'b1; end
    lat = -1; n_ack = 0; rdata = 32'hx;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      cyc0 = 1'b0; stb0 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0;
      if (i == pulse_at) begin
        if (d3) begin cyc3 = 1'b1; stb3 = 1'b1; end
        else    begin cyc0 = 1'b1; stb0 = 1'b1; end
      end
      if (d3 ? ack3 : ack0) begin
        n_ack++;
        if (lat < 0) begin lat = i; rdata = d3 ? dat3 : dat0; end
      end
    end
  endtask

  task automatic test_reset();
    #2;
    total_cnt++; if (ack0 !== 1'b0) $display("FAIL rst_ack0: got %b expected 0", ack0); else pass_cnt++;
    total_cnt++; if (stall0 !== 1'b0) $display("FAIL rst_stall0: got %b expected 0", stall0); else pass_cnt++;
    total_cnt++; if (dat0 !== 32'h0) $display("FAIL rst_dat0: got %h expected 00000000", dat0); else pass_cnt++;
    total_cnt++; if (ack3 !== 1'b0) $display("FAIL rst_ack3: got %b expected 0", ack3); else pass_cnt++;
    total_cnt++; if (stall3 !== 1'b0) $display("FAIL rst_stall3: got %b expected 0", stall3); else pass_cnt++;
    total_cnt++; if (dat3 !== 32'h0) $display("FAIL rst_dat3: got %h expected 00000000", dat3); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, n; logic [31:0] rd;
    xfer(1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 0, lat, n, rd);
    total_cnt++; if (lat !== 1) $display("FAIL basic_wr_lat: got %0d expected 1", lat); else pass_cnt++;
    total_cnt++; if (n !== 1) $display("FAIL basic_wr_nack: got %0d expected 1", n); else pass_cnt++;
    total_cnt++; if (dat0 !== 32'h0) $display("FAIL basic_wr_dat_o: got %h expected 00000000", dat0); else pass_cnt++;
    xfer(1'b0, 1'b0, 4'hF, 32'h10, 32'h0, 0, lat, n, rd);
    total_cnt++; if (lat !== 1) $display("FAIL basic_rd_lat: got %0d expected 1", lat); else pass_cnt++;
    total_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL basic_rd_data: got %h expected deadbeef", rd); else pass_cnt++;
    total_cnt++; if (dat0 !== 32'hDEADBEEF) $display("FAIL basic_rd_hold: got %h expected deadbeef", dat0); else pass_cnt++;
  endtask

  task automatic test_byte_write();
    int lat, n; logic [31:0] rd;
    xfer(1'b0, 1'b1, 4'b0010, 32'h10, 32'h00005500, 0, lat, n, rd);
    xfer(1'b0, 1'b0, 4'b0001, 32'h12, 32'h0, 0, lat, n, rd);
    total_cnt++; if (rd !== 32'hDEAD55EF) $display("FAIL byte_rd: got %h expected dead55ef", rd); else pass_cnt++;
    xfer(1'b0, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, 0, lat, n, rd);
    total_cnt++; if (n !== 1) $display("FAIL sel0_ack: got %0d expected 1", n); else pass_cnt++;
    xfer(1'b0, 1'b0, 4'hF, 32'h10, 32'h0, 0, lat, n, rd);
    total_cnt++; if (rd !== 32'hDEAD55EF) $display("FAIL sel0_rd: got %h expected dead55ef", rd); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    we = 1'b1; sel = 4'hF; adr = 32'h40; wdat = 32'hCAFEF00D;
    cyc0 = 1'b1; stb0 = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (ack0 !== 1'b1) $display("FAIL b2b_wr_ack: got %b expected 1", ack0); else pass_cnt++;
    we = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (ack0 !== 1'b0) $display("FAIL b2b_gap_ack: got %b expected 0", ack0); else pass_cnt++;
    @(posedge clk); #1;
    cyc0 = 1'b0; stb0 = 1'b0;
    total_cnt++; if (ack0 !== 1'b1) $display("FAIL b2b_rd_ack: got %b expected 1", ack0); else pass_cnt++;
    total_cnt++; if (dat0 !== 32'hCAFEF00D) $display("FAIL b2b_rd_data: got %h expected cafef00d", dat0); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int lat, n; logic [31:0] rd;
    xfer(1'b1, 1'b1, 4'hF, 32'h20, 32'h12345678, 0, lat, n, rd);
    total_cnt++; if (lat !== 4) $display("FAIL abort_lat: got %0d expected 4", lat); else pass_cnt++;
    total_cnt++; if (n !== 1) $display("FAIL abort_nack: got %0d expected 1", n); else pass_cnt++;
    xfer(1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 0, lat, n, rd);
    total_cnt++; if (rd !== 32'h12345678) $display("FAIL abort_rd: got %h expected 12345678", rd); else pass_cnt++;
  endtask

  task automatic test_wait_states();
    logic [4:0] exp_stall, exp_ack;
    exp_stall = 5'b01111;
    exp_ack   = 5'b01000;
    we = 1'b0; sel = 4'hF; adr = 32'h20;
    cyc3 = 1'b1; stb3 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      cyc3 = 1'b0; stb3 = 1'b0;
      total_cnt++;
      if (stall3 !== exp_stall[i-1]) $display("FAIL wait_stall_c%0d: got %b expected %b", i, stall3, exp_stall[i-1]);
      else pass_cnt++;
      total_cnt++;
      if (ack3 !== exp_ack[i-1]) $display("FAIL wait_ack_c%0d: got %b expected %b", i, ack3, exp_ack[i-1]);
      else pass_cnt++;
    end
    total_cnt++; if (dat3 !== 32'h12345678) $display("FAIL wait_rd_hold: got %h expected 12345678", dat3); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat, n; logic [31:0] rd;
    xfer(1'b1, 1'b1, 4'hF, 32'h30, 32'hAAAAAAAA, 0, lat, n, rd);
    we = 1'b1; sel = 4'hF; adr = 32'h30; wdat = 32'h55555555;
    cyc3 = 1'b1; stb3 = 1'b1;
    @(posedge clk); #1;
    cyc3 = 1'b0; stb3 = 1'b0;
    total_cnt++; if (stall3 !== 1'b1) $display("FAIL rmid_stall_wait: got %b expected 1", stall3); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total_cnt++; if (stall3 !== 1'b0) $display("FAIL rmid_async_stall: got %b expected 0", stall3); else pass_cnt++;
    total_cnt++; if (ack3 !== 1'b0) $display("FAIL rmid_async_ack: got %b expected 0", ack3); else pass_cnt++;
    total_cnt++; if (dat3 !== 32'h0) $display("FAIL rmid_async_dat: got %h expected 00000000", dat3); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack3) n++;
    end
    total_cnt++; if (n !== 0) $display("FAIL rmid_no_ack: got %0d expected 0", n); else pass_cnt++;
    xfer(1'b1, 1'b0, 4'hF, 32'h30, 32'h0, 0, lat, n, rd);
    total_cnt++; if (rd !== 32'hAAAAAAAA) $display("FAIL rmid_mem_kept: got %h expected aaaaaaaa", rd); else pass_cnt++;
  endtask

  task automatic test_wrap();
    int lat, n; logic [31:0] rd;
    xfer(1'b1, 1'b1, 4'hF, 32'h1000, 32'h1, 2, lat, n, rd);
    total_cnt++; if (n !== 1) $display("FAIL wrap_stray_stb_nack: got %0d expected 1", n); else pass_cnt++;
    total_cnt++; if (lat !== 4) $display("FAIL wrap_wr_lat: got %0d expected 4", lat); else pass_cnt++;
    xfer(1'b1, 1'b0, 4'hF, 32'h0000, 32'h0, 0, lat, n, rd);
    total_cnt++; if (rd !== 32'h1) $display("FAIL wrap_rd: got %h expected 00000001", rd); else pass_cnt++;
    xfer(1'b0, 1'b1, 4'hF, 32'h1000, 32'h1, 0, lat, n, rd);
    xfer(1'b0, 1'b0, 4'hF, 32'h0000, 32'h0, 0, lat, n, rd);
    total_cnt++; if (rd !== 32'h1) $display("FAIL wrap_rd_ws0: got %h expected 00000001", rd); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_write();
    test_back_to_back();
    test_abort();
    test_wait_states();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
